// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: req/ack data-memory port, store lane replication,
// load lane extract and sign/zero extension. Optional abort on missing ack: MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic              i_mem_rd,
  input  logic              i_mem_wr,
  input  logic              i_byte_rd,
  input  logic              i_2byte_rd,
  input  logic              i_4byte_rd,
  input  logic              i_signed_mem_rd,
  input  logic              i_byte_wr,
  input  logic              i_2byte_wr,
  input  logic              i_4byte_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_stall,
  output logic              o_dm_req,
  output logic              o_dm_we,
  output logic [ADDR_W-1:0] o_dm_addr,
  output logic [3:0]        o_dm_be,
  output logic [31:0]       o_dm_wdata,
  input  logic              i_dm_ack,
  input  logic [31:0]       i_dm_rdata,
  output logic [31:0]       o_rdata,
  output logic              o_rdata_valid,
  output logic              o_align_err,
  output logic              o_bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t              state_q, state_d;
  size_t               sz_q, sz_d;
  logic                sgn_q, sgn_d;
  logic [1:0]          off_q, off_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rdata_valid_q, rdata_valid_d;
  logic                align_err_q, align_err_d;
  logic                bus_err_q, bus_err_d;

  // Decode of the incoming instruction
  logic        op;
  logic        in_wr;
  logic [2:0]  sz_flags;
  size_t       in_sz;
  logic        misaligned;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;
  logic [31:0] ld_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    op       = i_valid & (i_mem_rd | i_mem_wr);
    // A combined rd+wr is treated as a store; its load flags are ignored.
    in_wr    = i_mem_wr;
    sz_flags = in_wr ? {i_4byte_wr, i_2byte_wr, i_byte_wr}
                     : {i_4byte_rd, i_2byte_rd, i_byte_rd};
    if (sz_flags[2])      in_sz = SZ_WORD;
    else if (sz_flags[1]) in_sz = SZ_HALF;
    else if (sz_flags[0]) in_sz = SZ_BYTE;
    else                  in_sz = SZ_WORD;

    misaligned = ((in_sz == SZ_HALF) && i_addr[0]) ||
                 ((in_sz == SZ_WORD) && (i_addr[1:0] != 2'b00));

    case (in_sz)
      SZ_BYTE: begin
        in_be    = 4'b0001 << i_addr[1:0];
        in_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        in_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        in_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        in_be    = 4'b1111;
        in_wdata = i_wdata;
      end
    endcase
  end

  // Load lane extract and extension from the latched size/offset
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = i_dm_rdata[7:0];
      2'd1:    ld_byte = i_dm_rdata[15:8];
      2'd2:    ld_byte = i_dm_rdata[23:16];
      default: ld_byte = i_dm_rdata[31:24];
    endcase
    ld_half = off_q[1] ? i_dm_rdata[31:16] : i_dm_rdata[15:0];
    case (sz_q)
      SZ_BYTE: ld_ext = {{24{sgn_q & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = {{16{sgn_q & ld_half[15]}}, ld_half};
      default: ld_ext = i_dm_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    sz_d          = sz_q;
    sgn_d         = sgn_q;
    off_d         = off_q;
    we_d          = we_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    align_err_d   = 1'b0;
    bus_err_d     = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d         = '0;
`endif
    o_stall       = 1'b0;
    o_dm_req      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op) begin
          if (misaligned) begin
            align_err_d = 1'b1;
          end else begin
            o_stall = 1'b1;
            sz_d    = in_sz;
            sgn_d   = i_signed_mem_rd;
            off_d   = i_addr[1:0];
            we_d    = in_wr;
            addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
            be_d    = in_be;
            wdata_d = in_wdata;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        o_stall  = 1'b1;
        o_dm_req = 1'b1;
        if (i_dm_ack) begin
          if (!we_q) begin
            rdata_d       = ld_ext;
            rdata_valid_d = 1'b1;
          end
          state_d = S_DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          bus_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      // Release cycle: the held instruction is still on the inputs and must not be re-accepted.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      sz_q          <= SZ_BYTE;
      sgn_q         <= 1'b0;
      off_q         <= 2'b00;
      we_q          <= 1'b0;
      addr_q        <= '0;
      be_q          <= 4'b0000;
      wdata_q       <= 32'h0;
      rdata_q       <= 32'h0;
      rdata_valid_q <= 1'b0;
      align_err_q   <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sz_q          <= sz_d;
      sgn_q         <= sgn_d;
      off_q         <= off_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      align_err_q   <= align_err_d;
      bus_err_q     <= bus_err_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
  assign o_bus_err = bus_err_q;
`else
  assign o_bus_err = 1'b0;
`endif

  assign o_dm_we       = we_q;
  assign o_dm_addr     = addr_q;
  assign o_dm_be       = be_q;
  assign o_dm_wdata    = wdata_q;
  assign o_rdata       = rdata_q;
  assign o_rdata_valid = rdata_valid_q;
  assign o_align_err   = align_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized loads/stores against a byte-level model.
module tb_mem_access_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid, i_mem_rd, i_mem_wr;
  logic        i_byte_rd, i_2byte_rd, i_4byte_rd, i_signed_mem_rd;
  logic        i_byte_wr, i_2byte_wr, i_4byte_wr;
  logic [31:0] i_addr, i_wdata;
  logic        o_stall, o_dm_req, o_dm_we;
  logic [31:0] o_dm_addr;
  logic [3:0]  o_dm_be;
  logic [31:0] o_dm_wdata;
  logic        i_dm_ack;
  logic [31:0] i_dm_rdata;
  logic [31:0] o_rdata;
  logic        o_rdata_valid, o_align_err, o_bus_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_ld = 32'h0;

  always #5 i_clk = ~i_clk;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
    .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr),
    .i_byte_rd(i_byte_rd), .i_2byte_rd(i_2byte_rd), .i_4byte_rd(i_4byte_rd),
    .i_signed_mem_rd(i_signed_mem_rd),
    .i_byte_wr(i_byte_wr), .i_2byte_wr(i_2byte_wr), .i_4byte_wr(i_4byte_wr),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_dm_req(o_dm_req), .o_dm_we(o_dm_we),
    .o_dm_addr(o_dm_addr), .o_dm_be(o_dm_be), .o_dm_wdata(o_dm_wdata),
    .i_dm_ack(i_dm_ack), .i_dm_rdata(i_dm_rdata),
    .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
    .o_align_err(o_align_err), .o_bus_err(o_bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 0; i_mem_rd = 0; i_mem_wr = 0;
    i_byte_rd = 0; i_2byte_rd = 0; i_4byte_rd = 0; i_signed_mem_rd = 0;
    i_byte_wr = 0; i_2byte_wr = 0; i_4byte_wr = 0;
    i_addr = 0; i_wdata = 0;
  endtask

  // rsz/wsz = {4byte,2byte,byte} flags. Called at posedge+1.
  task automatic run_op(input bit valid, input bit rd, input bit wr,
                        input logic [2:0] rsz, input logic [2:0] wsz, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int delay);
    bit          is_op, st, mis;
    logic [2:0]  f;
    int          nb, off, stalls;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, mask, raw;
    is_op = valid & (rd | wr);
    st    = wr;
    f     = st ? wsz : rsz;
    nb    = f[2] ? 4 : f[1] ? 2 : f[0] ? 1 : 4;
    off   = int'(addr[1:0]);
    mis   = (off % nb) != 0;
    exp_be = 4'(((1 << nb) - 1) << off);
    exp_wd = (nb == 1) ? wdata[7:0] * 32'h01010101 :
             (nb == 2) ? wdata[15:0] * 32'h00010001 : wdata;
    mask = (nb == 4) ? 32'hFFFFFFFF : (32'h1 << (8 * nb)) - 1;
    raw  = (rdata >> (8 * off)) & mask;
    if (sgn && nb != 4 && raw[8 * nb - 1]) raw = raw | ~mask;

    i_valid = valid; i_mem_rd = rd; i_mem_wr = wr;
    {i_4byte_rd, i_2byte_rd, i_byte_rd} = rsz;
    {i_4byte_wr, i_2byte_wr, i_byte_wr} = wsz;
    i_signed_mem_rd = sgn; i_addr = addr; i_wdata = wdata;
    #1;
    if (!is_op || mis) begin
      chk("nostall_t0", o_stall, 0);
      tick();
      idle_inputs();
      #1;
      chk("align_err", o_align_err, is_op);
      chk("noreq", o_dm_req, 0);
      chk("nostall", o_stall, 0);
      tick();
      chk("align_clr", o_align_err, 0);
      return;
    end
    chk("stall_t0", o_stall, 1);
    stalls = 1;
    tick();
    chk("req", o_dm_req, 1);
    chk("we", o_dm_we, st);
    chk("addr", o_dm_addr, {addr[31:2], 2'b00});
    if (st) begin
      chk("be", o_dm_be, exp_be);
      chk("wdata", o_dm_wdata, exp_wd);
    end
    for (int d = 0; d < delay; d++) begin
      chk("stall_wait", o_stall, 1);
      chk("req_wait", o_dm_req, 1);
      stalls++;
      tick();
    end
    chk("req_ack", o_dm_req, 1);
    if (o_stall) stalls++;
    i_dm_ack = 1; i_dm_rdata = rdata;
    tick();
    i_dm_ack = 0; i_dm_rdata = $urandom;
    chk("done_stall", o_stall, 0);
    chk("done_req", o_dm_req, 0);
    chk("rdata_valid", o_rdata_valid, !st);
    chk("bus_err", o_bus_err, 0);
    if (!st) last_ld = raw;
    chk("rdata", o_rdata, last_ld);
    chk("stall_cycles", stalls, delay + 2);
    tick();
    idle_inputs();
    #1;
    chk("after_req", o_dm_req, 0);
    chk("after_stall", o_stall, 0);
    chk("after_rv", o_rdata_valid, 0);
  endtask

  initial begin
    idle_inputs();
    i_rst_n = 0; i_dm_ack = 0; i_dm_rdata = 0;
    tick(); tick();
    chk("rst_stall", o_stall, 0);
    chk("rst_req", o_dm_req, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_rv", o_rdata_valid, 0);
    chk("rst_align", o_align_err, 0);
    chk("rst_buserr", o_bus_err, 0);
    chk("rst_be", o_dm_be, 0);
    i_rst_n = 1;
    tick();

    // sb 0x102, lb/lbu 0x101, lh misaligned, lw with 5-cycle ack delay
    run_op(1, 0, 1, 3'b000, 3'b001, 0, 32'h102, 32'h000000AB, 32'h0, 0);
    run_op(1, 1, 0, 3'b001, 3'b000, 1, 32'h101, 32'h0, 32'h0000F000, 0);
    run_op(1, 1, 0, 3'b001, 3'b000, 0, 32'h101, 32'h0, 32'h0000F000, 0);
    run_op(1, 1, 0, 3'b010, 3'b000, 1, 32'h103, 32'h0, 32'h0, 0);
    run_op(1, 1, 0, 3'b100, 3'b000, 0, 32'h200, 32'h0, 32'hDEADBEEF, 5);
    // rd+wr together is a store; no-size-flag store is a word
    run_op(1, 1, 1, 3'b001, 3'b000, 1, 32'h300, 32'h12345678, 32'hFFFFFFFF, 1);
    // neither rd nor wr: nothing happens
    run_op(1, 0, 0, 3'b111, 3'b111, 0, 32'h400, 32'h0, 32'h0, 0);

    for (int n = 0; n < 60; n++) begin
      bit v, r, w;
      int mode;
      mode = $urandom_range(0, 9);
      v = (mode != 0);
      r = (mode <= 5) || (mode == 9);
      w = (mode >= 5);
      run_op(v, r, w, 3'($urandom), 3'($urandom), 1'($urandom),
             $urandom, $urandom, $urandom, $urandom_range(0, 4));
    end

    // Synchronous reset in the middle of REQ; the late ack must be ignored
    i_valid = 1; i_mem_rd = 1; i_4byte_rd = 1; i_addr = 32'h500;
    tick();
    chk("mid_req", o_dm_req, 1);
    tick();
    i_rst_n = 0;
    tick();
    i_rst_n = 1;
    idle_inputs();
    #1;
    last_ld = 32'h0;
    chk("rst_mid_req", o_dm_req, 0);
    chk("rst_mid_stall", o_stall, 0);
    i_dm_ack = 1; i_dm_rdata = 32'hCAFEF00D;
    tick();
    i_dm_ack = 0;
    chk("late_ack_rv", o_rdata_valid, 0);
    chk("late_ack_req", o_dm_req, 0);
    chk("late_ack_rdata", o_rdata, last_ld);
    tick();
    chk("late_ack_idle", o_stall, 0);

    // No ack at all
    i_valid = 1; i_mem_rd = 1; i_4byte_rd = 1; i_addr = 32'h600;
    tick();
`ifdef MEM_TIMEOUT_EN
    for (int c = 0; c < 16; c++) begin
      chk("to_req", o_dm_req, 1);
      tick();
    end
    chk("to_buserr", o_bus_err, 1);
    chk("to_stall", o_stall, 0);
    chk("to_rv", o_rdata_valid, 0);
    chk("to_rdata", o_rdata, last_ld);
    tick();
    idle_inputs();
    #1;
    chk("to_buserr_clr", o_bus_err, 0);
`else
    for (int c = 0; c < 20; c++) begin
      chk("wait_req", o_dm_req, 1);
      chk("wait_buserr", o_bus_err, 0);
      tick();
    end
    i_dm_ack = 1; i_dm_rdata = 32'h87654321;
    tick();
    i_dm_ack = 0;
    chk("wait_rv", o_rdata_valid, 1);
    chk("wait_rdata", o_rdata, 32'h87654321);
    tick();
    idle_inputs();
`endif
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
